// File: rtl/host_cmd_pkg.sv
// Shared types and frame constants for the host command generator.
// Frame layout helpers keep the byte mux and length decode in one place.
package host_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_GAP      = 3'd2,
        ST_WAIT_RSP = 3'd3
    } state_e;

    localparam logic [7:0] HDR_WR      = 8'hAA;
    localparam logic [7:0] HDR_RD      = 8'hBB;
    localparam logic [7:0] HDR_ALU_OP  = 8'hCC;
    localparam logic [7:0] HDR_ALU_NOP = 8'hDD;

    function automatic logic [2:0] frame_len(input cmd_type_e t);
        logic [2:0] len;
        case (t)
            CMD_WR:     len = 3'd3;
            CMD_RD:     len = 3'd2;
            CMD_ALU_OP: len = 3'd4;
            default:    len = 3'd2;
        endcase
        return len;
    endfunction

    function automatic logic [7:0] frame_byte(
        input cmd_type_e  t,
        input logic [3:0] addr,
        input logic [7:0] data,
        input logic [7:0] opa,
        input logic [7:0] opb,
        input logic [3:0] fun,
        input logic [2:0] idx
    );
        logic [7:0] b;
        b = '0;
        case (t)
            CMD_WR: begin
                case (idx)
                    3'd0:    b = HDR_WR;
                    3'd1:    b = {4'b0, addr};
                    3'd2:    b = data;
                    default: b = '0;
                endcase
            end
            CMD_RD: begin
                case (idx)
                    3'd0:    b = HDR_RD;
                    3'd1:    b = {4'b0, addr};
                    default: b = '0;
                endcase
            end
            CMD_ALU_OP: begin
                case (idx)
                    3'd0:    b = HDR_ALU_OP;
                    3'd1:    b = opa;
                    3'd2:    b = opb;
                    3'd3:    b = {4'b0, fun};
                    default: b = '0;
                endcase
            end
            default: begin
                case (idx)
                    3'd0:    b = HDR_ALU_NOP;
                    3'd1:    b = {4'b0, fun};
                    default: b = '0;
                endcase
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/host_cmd_gen.sv
// Host command framer: serialises RF/ALU commands into UART bytes and
// waits (with timeout) for the single-byte response.
module host_cmd_gen
    import host_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    input  logic [1:0] CMD_TYPE,
    input  logic [3:0] CMD_ADDR,
    input  logic [7:0] CMD_DATA,
    input  logic [7:0] CMD_OPA,
    input  logic [7:0] CMD_OPB,
    input  logic [3:0] CMD_FUN,
    output logic       CMD_READY,
    output logic [7:0] TX_P_DATA,
    output logic       TX_D_VLD,
    input  logic       TX_BUSY,
    input  logic [7:0] RX_P_DATA,
    input  logic       RX_D_VLD,
    output logic [7:0] RSP_DATA,
    output logic       RSP_VALID,
    output logic       RSP_TIMEOUT,
    output logic       CMD_DONE
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_n;
    logic [2:0] idx_q, idx_n;
    logic [15:0] cnt_q, cnt_n;
    cmd_type_e  type_q, type_n;
    logic [3:0] addr_q, addr_n;
    logic [7:0] data_q, data_n;
    logic [7:0] opa_q, opa_n;
    logic [7:0] opb_q, opb_n;
    logic [3:0] fun_q, fun_n;

    logic       ready_n, tx_vld_n, rsp_vld_n, tmo_n, done_n;
    logic [7:0] tx_data_n, rsp_data_n;

    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        cnt_n      = cnt_q;
        type_n     = type_q;
        addr_n     = addr_q;
        data_n     = data_q;
        opa_n      = opa_q;
        opb_n      = opb_q;
        fun_n      = fun_q;
        rsp_data_n = RSP_DATA;
        rsp_vld_n  = 1'b0;
        tmo_n      = 1'b0;
        done_n     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    type_n  = cmd_type_e'(CMD_TYPE);
                    addr_n  = CMD_ADDR;
                    data_n  = CMD_DATA;
                    opa_n   = CMD_OPA;
                    opb_n   = CMD_OPB;
                    fun_n   = CMD_FUN;
                    idx_n   = '0;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (TX_D_VLD && !TX_BUSY) begin
                    idx_n   = idx_q + 3'd1;
                    state_n = ST_GAP;
                    // Write completion pulse is registered here so it shows
                    // during the closing GAP cycle, not after it.
                    if (type_q == CMD_WR && idx_n == frame_len(type_q))
                        done_n = 1'b1;
                end
            end
            ST_GAP: begin
                if (idx_q < frame_len(type_q)) begin
                    state_n = ST_SEND;
                end else if (type_q == CMD_WR) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n   = '0;
                    state_n = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (RX_D_VLD) begin
                    rsp_data_n = RX_P_DATA;
                    rsp_vld_n  = 1'b1;
                    done_n     = 1'b1;
                    state_n    = ST_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        ready_n   = (state_n == ST_IDLE);
        tx_vld_n  = (state_n == ST_SEND);
        tx_data_n = tx_vld_n ? frame_byte(type_n, addr_n, data_n, opa_n, opb_n, fun_n, idx_n)
                             : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            type_q      <= CMD_WR;
            addr_q      <= '0;
            data_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            fun_q       <= '0;
            CMD_READY   <= 1'b1;
            TX_D_VLD    <= 1'b0;
            TX_P_DATA   <= '0;
            RSP_DATA    <= '0;
            RSP_VALID   <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            CMD_DONE    <= 1'b0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            type_q      <= type_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            opa_q       <= opa_n;
            opb_q       <= opb_n;
            fun_q       <= fun_n;
            CMD_READY   <= ready_n;
            TX_D_VLD    <= tx_vld_n;
            TX_P_DATA   <= tx_data_n;
            RSP_DATA    <= rsp_data_n;
            RSP_VALID   <= rsp_vld_n;
            RSP_TIMEOUT <= tmo_n;
            CMD_DONE    <= done_n;
        end
    end

endmodule

// File: tb/tb_host_cmd_gen.sv
// Directed bench for host_cmd_gen with a 16-cycle response timeout.
module tb_host_cmd_gen;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic [1:0] CMD_TYPE;
    logic [3:0] CMD_ADDR;
    logic [7:0] CMD_DATA;
    logic [7:0] CMD_OPA;
    logic [7:0] CMD_OPB;
    logic [3:0] CMD_FUN;
    logic       CMD_READY;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RSP_DATA;
    logic       RSP_VALID;
    logic       RSP_TIMEOUT;
    logic       CMD_DONE;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    host_cmd_gen #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
        .CMD_DATA(CMD_DATA), .CMD_OPA(CMD_OPA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
        .CMD_READY(CMD_READY), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT),
        .CMD_DONE(CMD_DONE)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                         input string tag);
        checks++;
        if (CMD_READY !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_before_issue CMD_READY got %b want 1", tag, CMD_READY);
        end
        CMD_VALID = 1'b1; CMD_TYPE = t; CMD_ADDR = a; CMD_DATA = d;
        CMD_OPA = oa; CMD_OPB = ob; CMD_FUN = f;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({CMD_READY, TX_D_VLD, RSP_VALID, RSP_TIMEOUT, CMD_DONE} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags {READY,TXV,RSPV,TMO,DONE} got %b want 10000",
                     {CMD_READY, TX_D_VLD, RSP_VALID, RSP_TIMEOUT, CMD_DONE});
        end
        checks++;
        if (TX_P_DATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_data got %h want 00", TX_P_DATA);
        end
        checks++;
        if (RSP_DATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_rsp_data got %h want 00", RSP_DATA);
        end
    endtask

    task automatic test_write(input logic [3:0] a, input logic [7:0] d, input string tag);
        logic       ev, edone, erdy;
        logic [7:0] ed;
        issue(2'd0, a, d, 8'h00, 8'h00, 4'h0, tag);
        for (int c = 1; c <= 8; c++) begin
            ev    = (c == 1 || c == 3 || c == 5);
            ed    = (c == 1) ? 8'hAA : (c == 3) ? {4'b0, a} : d;
            edone = (c == 6);
            erdy  = (c >= 7);
            checks++;
            if (TX_D_VLD !== ev) begin
                failures++;
                $display("FAIL %s_tx_vld cycle %0d got %b want %b", tag, c, TX_D_VLD, ev);
            end
            if (ev) begin
                checks++;
                if (TX_P_DATA !== ed) begin
                    failures++;
                    $display("FAIL %s_tx_data cycle %0d got %h want %h", tag, c, TX_P_DATA, ed);
                end
            end
            checks++;
            if ({CMD_DONE, RSP_VALID, CMD_READY} !== {edone, 1'b0, erdy}) begin
                failures++;
                $display("FAIL %s_flags cycle %0d {DONE,RSPV,READY} got %b want %b",
                         tag, c, {CMD_DONE, RSP_VALID, CMD_READY}, {edone, 1'b0, erdy});
            end
            tick();
        end
    endtask

    task automatic test_rx_ignored_idle();
        RX_P_DATA = 8'h99; RX_D_VLD = 1'b1;
        tick();
        RX_D_VLD = 1'b0;
        tick();
        checks++;
        if (RSP_VALID !== 1'b0 || RSP_DATA !== 8'h00) begin
            failures++;
            $display("FAIL rx_idle_ignored RSPV/RSP_DATA got %b/%h want 0/00", RSP_VALID, RSP_DATA);
        end
    endtask

    // Generic response/timeout scenario: two-byte frame, optional RX at rx_cycle.
    task automatic run_wait(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input int rx_cycle, input logic [7:0] rx_byte,
                            input int end_cycle, input logic exp_tmo,
                            input logic [7:0] old_rsp);
        logic       ev, epulse;
        logic [7:0] erd;
        for (int c = 1; c <= end_cycle + 1; c++) begin
            ev     = (c == 1 || c == 3);
            epulse = (c == end_cycle);
            erd    = (!exp_tmo && c >= end_cycle) ? rx_byte : old_rsp;
            checks++;
            if (TX_D_VLD !== ev || (ev && TX_P_DATA !== ((c == 1) ? b0 : b1))) begin
                failures++;
                $display("FAIL %s_tx cycle %0d vld/data got %b/%h want %b/%h",
                         tag, c, TX_D_VLD, TX_P_DATA, ev, (c == 1) ? b0 : b1);
            end
            checks++;
            if ({RSP_VALID, RSP_TIMEOUT, CMD_DONE, CMD_READY} !==
                {epulse & ~exp_tmo, epulse & exp_tmo, epulse, (c >= end_cycle)}) begin
                failures++;
                $display("FAIL %s_pulses cycle %0d {RSPV,TMO,DONE,READY} got %b want %b", tag, c,
                         {RSP_VALID, RSP_TIMEOUT, CMD_DONE, CMD_READY},
                         {epulse & ~exp_tmo, epulse & exp_tmo, epulse, (c >= end_cycle)});
            end
            checks++;
            if (RSP_DATA !== erd) begin
                failures++;
                $display("FAIL %s_rsp_data cycle %0d got %h want %h", tag, c, RSP_DATA, erd);
            end
            RX_D_VLD  = (c == rx_cycle);
            RX_P_DATA = (c == rx_cycle) ? rx_byte : 8'h00;
            tick();
        end
        RX_D_VLD = 1'b0;
    endtask

    task automatic test_read();
        issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, "read");
        run_wait("read", 8'hBB, 8'h02, 13, 8'h7E, 14, 1'b0, 8'h00);
    endtask

    task automatic test_alu_busy();
        logic [7:0] exp_b [4];
        int k, held;
        logic seen;
        exp_b[0] = 8'hCC; exp_b[1] = 8'h10; exp_b[2] = 8'h22; exp_b[3] = 8'h01;
        k = 0; held = 0; seen = 1'b0;
        issue(2'd2, 4'h0, 8'h00, 8'h10, 8'h22, 4'h1, "alu_busy");
        for (int c = 1; c <= 80 && !seen; c++) begin
            if (CMD_DONE) begin
                seen = 1'b1;
                checks++;
                if (RSP_TIMEOUT !== 1'b1 || RSP_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL alu_busy_end TMO/RSPV got %b/%b want 1/0", RSP_TIMEOUT, RSP_VALID);
                end
            end else begin
                if (TX_D_VLD) begin
                    checks++;
                    if (k >= 4) begin
                        failures++;
                        $display("FAIL alu_busy_extra_byte cycle %0d got %h want no byte", c, TX_P_DATA);
                        TX_BUSY = 1'b0;
                    end else begin
                        if (TX_P_DATA !== exp_b[k]) begin
                            failures++;
                            $display("FAIL alu_busy_byte%0d cycle %0d got %h want %h",
                                     k, c, TX_P_DATA, exp_b[k]);
                        end
                        if (held < 3) begin
                            TX_BUSY = 1'b1; held++;
                        end else begin
                            TX_BUSY = 1'b0; held = 0; k++;
                        end
                    end
                end else begin
                    TX_BUSY = 1'b0;
                end
                tick();
            end
        end
        TX_BUSY = 1'b0;
        checks++;
        if (!seen || k != 4) begin
            failures++;
            $display("FAIL alu_busy_complete done/bytes got %b/%0d want 1/4", seen, k);
        end
        tick();
    endtask

    task automatic test_timeout();
        issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA, "timeout");
        run_wait("timeout", 8'hDD, 8'h0A, 0, 8'h00, 21, 1'b1, 8'h7E);
    endtask

    task automatic test_boundary();
        issue(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, "boundary");
        run_wait("boundary", 8'hBB, 8'h03, 20, 8'h5A, 21, 1'b0, 8'h7E);
    endtask

    task automatic test_reset_ignore();
        logic [7:0] ed;
        issue(2'd2, 4'h0, 8'h00, 8'hAB, 8'hCD, 4'h7, "rst_mid");
        CMD_VALID = 1'b1; CMD_TYPE = 2'd0; CMD_ADDR = 4'hF; CMD_DATA = 8'hEE;
        for (int c = 1; c <= 5; c++) begin
            ed = (c == 1) ? 8'hCC : (c == 3) ? 8'hAB : 8'hCD;
            checks++;
            if (TX_D_VLD !== (c % 2 == 1) || ((c % 2 == 1) && TX_P_DATA !== ed) || CMD_READY !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_send cycle %0d vld/data/ready got %b/%h/%b want %b/%h/0",
                         c, TX_D_VLD, TX_P_DATA, CMD_READY, (c % 2 == 1), ed);
            end
            if (c == 4) CMD_VALID = 1'b0;
            if (c < 5) tick();
        end
        #1 RST = 1'b0;
        #1;
        checks++;
        if (TX_D_VLD !== 1'b0 || CMD_READY !== 1'b1 || CMD_DONE !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async vld/ready/done got %b/%b/%b want 0/1/0",
                     TX_D_VLD, CMD_READY, CMD_DONE);
        end
        tick();
        tick();
        RST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({TX_D_VLD, CMD_DONE, RSP_VALID, RSP_TIMEOUT, CMD_READY} !== 5'b00001
                || RSP_DATA !== 8'h00) begin
                failures++;
                $display("FAIL rst_mid_after cycle %0d {TXV,DONE,RSPV,TMO,READY}/RSP got %b/%h want 00001/00",
                         c, {TX_D_VLD, CMD_DONE, RSP_VALID, RSP_TIMEOUT, CMD_READY}, RSP_DATA);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; CMD_VALID = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_DATA = '0;
        CMD_OPA = '0; CMD_OPB = '0; CMD_FUN = '0; TX_BUSY = 1'b0;
        RX_P_DATA = '0; RX_D_VLD = 1'b0;
        tick();
        tick();
        test_reset();
        RST = 1'b1;
        tick();
        test_write(4'h5, 8'h3C, "write");
        test_rx_ignored_idle();
        test_read();
        test_alu_busy();
        test_timeout();
        test_boundary();
        test_reset_ignore();
        test_write(4'h9, 8'h81, "back_to_back");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
